cnt_ctrl: RTL and testbench
===========================

# cnt_ctrl

Counter control sequencer for the timer's 64-bit up-counter. Produces the per-cycle `cnt_en` strobe consumed by the counter, applying the programmable prescaler (`div_en`/`div_val`) and a debug-halt request/acknowledge handshake. Sits between the register file (control fields) and the counter datapath; it never touches the count value itself.

## Interface
- `DIV_W`, 8: width of internal prescaler counter.
- `DIV_MAX`, 8: largest honoured `div_val`; prescale period = 2^`div_val` cycles.

- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `timer_en`  in  1  timer enable from control register.
- `div_en`  in  1  prescaler enable.
- `div_val`  in  4  prescaler exponent.
- `dbg_mode`  in  1  CPU in debug mode.
- `halt_req`  in  1  debug halt request.
- `cnt_en`  out  1  count strobe to counter, one increment per high cycle.
- `halt_ack`  out  1  counting frozen by debug halt.

## Operation
- FSM states: IDLE, RUN, HALT. Halt condition `hc = halt_req & dbg_mode`.
- IDLE -> HALT if `hc`; else IDLE -> RUN if `timer_en`.
- RUN -> HALT if `hc`; else RUN -> IDLE if `!timer_en`.
- HALT -> RUN when `!hc & timer_en`; HALT -> IDLE when `!hc & !timer_en`.
- Limit: `lim = div_en ? (2^min(div_val,DIV_MAX) - 1) : 0`. `div_val` 9..15 clamps to 8 (lim 255).
- `div_cnt` (DIV_W bits): in RUN increments, wraps to 0 when equal to `lim`; held in HALT; cleared in IDLE.
- `cnt_en = (state==RUN) & (div_cnt==lim) & !cfg_chg`; combinational from registers and config inputs.
- `cfg_chg`: `div_en` or `div_val` differs from its registered copy. On `cfg_chg`, `div_cnt` loads 0 at the next edge and `cnt_en` is suppressed that cycle; next period starts from 0 with new limit.
- `timer_en` falling while in HALT: stay HALT, clear `div_cnt`.
- `halt_ack = (state==HALT)`, registered.

## Timing
- Reset: state IDLE, `div_cnt`=0, config copies=0, `cnt_en`=0, `halt_ack`=0.
- `timer_en` sampled high at edge k -> RUN after k; with `div_en`=0, `cnt_en` high from cycle k, first increment at edge k+1, then every cycle.
- `div_en`=1, `div_val`=n: `cnt_en` high one cycle in every 2^n, first pulse 2^n-1 cycles after entering RUN.
- `hc` sampled high at edge h -> `halt_ack`=1 and `cnt_en`=0 from cycle h onward; no strobe lost or duplicated across halt; resume continues the interrupted prescale period.
- `hc` low at edge r -> `halt_ack`=0 after r; `cnt_en` may assert in same cycle.
- `timer_en` low at edge -> IDLE, `cnt_en`=0 next cycle.
- Reset asserted mid-operation: all state and outputs return to reset values immediately (asynchronous).

## Configuration
- `CNT_CTRL_DBG_HALT_EN` defined: HALT state and handshake as above.
- Not defined: `halt_req`/`dbg_mode` ignored, HALT state absent, `halt_ack` tied 0; IDLE/RUN and prescaler unchanged.

## Structure
- Package `cnt_ctrl_pkg`: state enum (IDLE, RUN, HALT), `DIV_W`, `DIV_MAX`, limit-compute function.
- Sub-module `cnt_ctrl_presc`: `div_cnt`, limit clamp, config-change detect, terminal-count output; FSM stays in top.

## Test plan
- Reset, `timer_en`=1, `div_en`=0, 10 cycles -> `cnt_en` high all 10 cycles, from cycle after enable sample.
- `div_en`=1, `div_val`=3 -> `cnt_en` pulses once every 8 cycles, first pulse 7 cycles after RUN entry; `div_val`=12 -> period 256.
- `div_val` changed 2 -> 1 mid-period -> no pulse in change cycle; next pulse 1 cycle after `div_cnt` restart, then period 2.
- `div_val`=2, `dbg_mode`=1, `halt_req` pulsed 5 cycles at `div_cnt`=1 -> `halt_ack` high 5 cycles, `cnt_en`=0, then pulse 2 cycles after release.
- `timer_en` dropped while halted, then `halt_req` released -> state IDLE, `div_cnt`=0, `cnt_en`=0, `halt_ack`=0.
- Build without `CNT_CTRL_DBG_HALT_EN`, assert `hc` -> `cnt_en` unaffected, `halt_ack` stays 0.

Source files
------------

// File: rtl/cnt_ctrl_pkg.sv
// Shared types and constants for the timer counter-control sequencer.
// Sizes the prescaler and provides the prescale-limit helper.
package cnt_ctrl_pkg;

  localparam int unsigned DIV_W   = 8;
  localparam int unsigned DIV_MAX = 8;
  localparam int unsigned VAL_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  // Terminal count for the prescaler: 2^min(val,DIV_MAX)-1, or 0 when bypassed.
  // A shift of DIV_W or more clears the mask, so val==DIV_MAX yields all ones.
  function automatic logic [DIV_W-1:0] lim_calc(input logic en, input logic [VAL_W-1:0] val);
    logic [VAL_W-1:0] exp_v;
    logic [DIV_W-1:0] ones;
    exp_v = (32'(val) > DIV_MAX) ? VAL_W'(DIV_MAX) : val;
    ones  = '1;
    return en ? ~(ones << exp_v) : '0;
  endfunction

endpackage

// File: rtl/cnt_ctrl_presc.sv
// Prescaler for the counter-control sequencer: period counter, limit clamp,
// configuration-change restart and terminal-count flag.
module cnt_ctrl_presc
  import cnt_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             halt,
  input  logic             timer_en,
  input  logic             div_en,
  input  logic [VAL_W-1:0] div_val,
  output logic             tc_c
);

  logic             div_en_q;
  logic [VAL_W-1:0] div_val_q;
  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] lim;
  logic             cfg_chg;

  assign lim     = lim_calc(div_en, div_val);
  assign cfg_chg = (div_en != div_en_q) || (div_val != div_val_q);

  // A config change restarts the period, so the old limit never strobes.
  assign tc_c = (div_cnt == lim) && !cfg_chg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_en_q  <= 1'b0;
      div_val_q <= '0;
      div_cnt   <= '0;
    end else begin
      div_en_q  <= div_en;
      div_val_q <= div_val;
      if (cfg_chg) begin
        div_cnt <= '0;
      end else if (run) begin
        div_cnt <= (div_cnt == lim) ? '0 : div_cnt + DIV_W'(1);
      end else if (halt) begin
        // Halt freezes the period; dropping the enable while halted abandons it.
        if (!timer_en) div_cnt <= '0;
      end else begin
        div_cnt <= '0;
      end
    end
  end

`ifndef SYNTHESIS
  // The period counter never runs past the active limit.
  assert property (@(posedge clk) disable iff (!rst_n) cfg_chg || (div_cnt <= lim));
`endif

endmodule

// File: rtl/cnt_ctrl.sv
// Counter control sequencer: IDLE/RUN/HALT FSM gating the prescaled count strobe.
// Debug-halt handshake is built only when CNT_CTRL_DBG_HALT_EN is defined.
module cnt_ctrl
  import cnt_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             timer_en,
  input  logic             div_en,
  input  logic [VAL_W-1:0] div_val,
  input  logic             dbg_mode,
  input  logic             halt_req,
  output logic             cnt_en,
  output logic             halt_ack
);

  state_t state;
  logic   tc_c;
  logic   hc_c;

`ifdef CNT_CTRL_DBG_HALT_EN
  assign hc_c = halt_req & dbg_mode;
`else
  logic unused_dbg;
  assign unused_dbg = halt_req ^ dbg_mode;
  assign hc_c       = 1'b0;
  assign halt_ack   = 1'b0;
`endif

  // Halt takes priority from every state; otherwise timer_en selects RUN/IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
`ifdef CNT_CTRL_DBG_HALT_EN
      halt_ack <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (hc_c)          state <= HALT;
          else if (timer_en) state <= RUN;
        end
        RUN: begin
          if (hc_c)           state <= HALT;
          else if (!timer_en) state <= IDLE;
        end
        HALT: begin
          if (!hc_c) state <= timer_en ? RUN : IDLE;
        end
        default: state <= IDLE;
      endcase
`ifdef CNT_CTRL_DBG_HALT_EN
      // Next state is HALT exactly when the halt condition is sampled high.
      halt_ack <= hc_c;
`endif
    end
  end

  cnt_ctrl_presc u_presc (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (state == RUN),
    .halt     (state == HALT),
    .timer_en (timer_en),
    .div_en   (div_en),
    .div_val  (div_val),
    .tc_c     (tc_c)
  );

  assign cnt_en = (state == RUN) && tc_c;

`ifndef SYNTHESIS
  assert property (@(posedge clk) disable iff (!rst_n) !(cnt_en && halt_ack));
`endif

endmodule

// File: tb/tb_cnt_ctrl.sv
// Directed self-checking bench for cnt_ctrl; halt scenarios follow CNT_CTRL_DBG_HALT_EN.
module tb_cnt_ctrl;

  logic       clk;
  logic       rst_n;
  logic       timer_en;
  logic       div_en;
  logic [3:0] div_val;
  logic       dbg_mode;
  logic       halt_req;
  logic       cnt_en;
  logic       halt_ack;

  int checks;
  int errors;

  cnt_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .timer_en (timer_en),
    .div_en   (div_en),
    .div_val  (div_val),
    .dbg_mode (dbg_mode),
    .halt_req (halt_req),
    .cnt_en   (cnt_en),
    .halt_ack (halt_ack)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Inputs change just after the rising edge; outputs are sampled at the falling edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; timer_en = 1'b1; div_en = 1'b0; div_val = 4'd0;
    dbg_mode = 1'b0; halt_req = 1'b0;
    cyc(); mid();
    checks++;
    if ({cnt_en, halt_ack} !== 2'b00) begin
      errors++; $display("FAIL reset_hold got %b exp 00", {cnt_en, halt_ack});
    end
    cyc(); timer_en = 1'b0; rst_n = 1'b1; mid();
    checks++;
    if ({cnt_en, halt_ack} !== 2'b00) begin
      errors++; $display("FAIL reset_release got %b exp 00", {cnt_en, halt_ack});
    end
  endtask

  task automatic test_div_off();
    cyc(); timer_en = 1'b1; mid();
    checks++;
    if (cnt_en !== 1'b0) begin
      errors++; $display("FAIL off_idle cnt_en got %b exp 0", cnt_en);
    end
    for (int i = 0; i < 10; i++) begin
      cyc(); mid();
      checks++;
      if (cnt_en !== 1'b1) begin
        errors++; $display("FAIL off_run[%0d] cnt_en got %b exp 1", i, cnt_en);
      end
    end
    cyc(); timer_en = 1'b0; mid();
    checks++;
    if (cnt_en !== 1'b1) begin
      errors++; $display("FAIL off_drop_cycle cnt_en got %b exp 1", cnt_en);
    end
    cyc(); mid();
    checks++;
    if (cnt_en !== 1'b0) begin
      errors++; $display("FAIL off_to_idle cnt_en got %b exp 0", cnt_en);
    end
  endtask

  task automatic test_presc();
    logic e;
    cyc(); div_en = 1'b1; div_val = 4'd3; mid();
    cyc(); timer_en = 1'b1; mid();
    for (int i = 0; i < 24; i++) begin
      cyc(); mid();
      e = ((i % 8) == 7);
      checks++;
      if (cnt_en !== e) begin
        errors++; $display("FAIL presc8[%0d] cnt_en got %b exp %b", i, cnt_en, e);
      end
    end
    // Exponent 12 clamps to 8: period 256.
    cyc(); div_val = 4'd12; mid();
    checks++;
    if (cnt_en !== 1'b0) begin
      errors++; $display("FAIL presc_chg12 cnt_en got %b exp 0", cnt_en);
    end
    for (int j = 0; j < 260; j++) begin
      cyc(); mid();
      e = (j == 255);
      checks++;
      if (cnt_en !== e) begin
        errors++; $display("FAIL presc256[%0d] cnt_en got %b exp %b", j, cnt_en, e);
      end
    end
    cyc(); timer_en = 1'b0; mid();
    cyc(); mid();
    checks++;
    if (cnt_en !== 1'b0) begin
      errors++; $display("FAIL presc_idle cnt_en got %b exp 0", cnt_en);
    end
  endtask

  task automatic test_cfg_change();
    logic e;
    cyc(); div_val = 4'd2; mid();
    cyc(); timer_en = 1'b1; mid();
    for (int i = 0; i < 7; i++) begin
      cyc(); mid();
      e = ((i % 4) == 3);
      checks++;
      if (cnt_en !== e) begin
        errors++; $display("FAIL chg_pre[%0d] cnt_en got %b exp %b", i, cnt_en, e);
      end
    end
    // Would have been the terminal cycle of the period-4 sequence.
    cyc(); div_val = 4'd1; mid();
    checks++;
    if (cnt_en !== 1'b0) begin
      errors++; $display("FAIL chg_suppress cnt_en got %b exp 0", cnt_en);
    end
    for (int k = 0; k < 6; k++) begin
      cyc(); mid();
      e = ((k % 2) == 1);
      checks++;
      if (cnt_en !== e) begin
        errors++; $display("FAIL chg_post[%0d] cnt_en got %b exp %b", k, cnt_en, e);
      end
    end
    cyc(); timer_en = 1'b0; mid();
    cyc(); mid();
    checks++;
    if (cnt_en !== 1'b0) begin
      errors++; $display("FAIL chg_idle cnt_en got %b exp 0", cnt_en);
    end
  endtask

`ifdef CNT_CTRL_DBG_HALT_EN
  task automatic test_halt();
    cyc(); div_val = 4'd2; mid();
    cyc(); timer_en = 1'b1; mid();
    cyc(); mid();
    cyc(); dbg_mode = 1'b1; halt_req = 1'b1; mid();
    checks++;
    if ({cnt_en, halt_ack} !== 2'b00) begin
      errors++; $display("FAIL halt_pre got %b exp 00", {cnt_en, halt_ack});
    end
    for (int k = 1; k <= 5; k++) begin
      cyc(); if (k == 5) halt_req = 1'b0; mid();
      checks++;
      if ({cnt_en, halt_ack} !== 2'b01) begin
        errors++; $display("FAIL halt_hold[%0d] got %b exp 01", k, {cnt_en, halt_ack});
      end
    end
    cyc(); mid();
    checks++;
    if ({cnt_en, halt_ack} !== 2'b00) begin
      errors++; $display("FAIL halt_resume got %b exp 00", {cnt_en, halt_ack});
    end
    cyc(); mid();
    checks++;
    if ({cnt_en, halt_ack} !== 2'b10) begin
      errors++; $display("FAIL halt_resume_pulse got %b exp 10", {cnt_en, halt_ack});
    end
    cyc(); timer_en = 1'b0; mid();
    cyc(); mid();
    checks++;
    if ({cnt_en, halt_ack} !== 2'b00) begin
      errors++; $display("FAIL halt_idle got %b exp 00", {cnt_en, halt_ack});
    end
    cyc(); dbg_mode = 1'b0; halt_req = 1'b1; mid();
    cyc(); mid();
    checks++;
    if ({cnt_en, halt_ack} !== 2'b00) begin
      errors++; $display("FAIL nodbg_no_halt got %b exp 00", {cnt_en, halt_ack});
    end
    cyc(); dbg_mode = 1'b1; mid();
    cyc(); halt_req = 1'b0; mid();
    checks++;
    if ({cnt_en, halt_ack} !== 2'b01) begin
      errors++; $display("FAIL idle_to_halt got %b exp 01", {cnt_en, halt_ack});
    end
    cyc(); mid();
    checks++;
    if ({cnt_en, halt_ack} !== 2'b00) begin
      errors++; $display("FAIL halt_to_idle got %b exp 00", {cnt_en, halt_ack});
    end
  endtask

  task automatic test_halt_clear();
    logic e;
    cyc(); timer_en = 1'b1; mid();
    cyc(); mid();
    cyc(); mid();
    cyc(); halt_req = 1'b1; mid();
    checks++;
    if ({cnt_en, halt_ack} !== 2'b00) begin
      errors++; $display("FAIL clr_pre got %b exp 00", {cnt_en, halt_ack});
    end
    cyc(); timer_en = 1'b0; mid();
    checks++;
    if ({cnt_en, halt_ack} !== 2'b01) begin
      errors++; $display("FAIL clr_halted got %b exp 01", {cnt_en, halt_ack});
    end
    cyc(); timer_en = 1'b1; halt_req = 1'b0; mid();
    checks++;
    if ({cnt_en, halt_ack} !== 2'b01) begin
      errors++; $display("FAIL clr_still_halted got %b exp 01", {cnt_en, halt_ack});
    end
    // Period restarts from zero because the enable dropped during the halt.
    for (int k = 0; k < 4; k++) begin
      cyc(); mid();
      e = (k == 3);
      checks++;
      if ({cnt_en, halt_ack} !== {e, 1'b0}) begin
        errors++; $display("FAIL clr_resume[%0d] got %b exp %b0", k, {cnt_en, halt_ack}, e);
      end
    end
    cyc(); halt_req = 1'b1; mid();
    cyc(); timer_en = 1'b0; mid();
    checks++;
    if ({cnt_en, halt_ack} !== 2'b01) begin
      errors++; $display("FAIL drop_halted got %b exp 01", {cnt_en, halt_ack});
    end
    cyc(); mid();
    checks++;
    if ({cnt_en, halt_ack} !== 2'b01) begin
      errors++; $display("FAIL drop_stay_halt got %b exp 01", {cnt_en, halt_ack});
    end
    cyc(); halt_req = 1'b0; mid();
    cyc(); mid();
    checks++;
    if ({cnt_en, halt_ack} !== 2'b00) begin
      errors++; $display("FAIL drop_release_idle got %b exp 00", {cnt_en, halt_ack});
    end
    cyc(); timer_en = 1'b1; mid();
    for (int k = 0; k < 4; k++) begin
      cyc(); mid();
      e = (k == 3);
      checks++;
      if (cnt_en !== e) begin
        errors++; $display("FAIL drop_restart[%0d] cnt_en got %b exp %b", k, cnt_en, e);
      end
    end
    cyc(); timer_en = 1'b0; mid();
    cyc(); mid();
  endtask
`else
  task automatic test_no_halt();
    cyc(); div_en = 1'b0; div_val = 4'd0; mid();
    cyc(); timer_en = 1'b1; dbg_mode = 1'b1; halt_req = 1'b1; mid();
    checks++;
    if ({cnt_en, halt_ack} !== 2'b00) begin
      errors++; $display("FAIL nohalt_idle got %b exp 00", {cnt_en, halt_ack});
    end
    for (int k = 0; k < 6; k++) begin
      cyc(); mid();
      checks++;
      if ({cnt_en, halt_ack} !== 2'b10) begin
        errors++; $display("FAIL nohalt_run[%0d] got %b exp 10", k, {cnt_en, halt_ack});
      end
    end
    cyc(); timer_en = 1'b0; halt_req = 1'b0; dbg_mode = 1'b0; mid();
    cyc(); mid();
    checks++;
    if ({cnt_en, halt_ack} !== 2'b00) begin
      errors++; $display("FAIL nohalt_idle_end got %b exp 00", {cnt_en, halt_ack});
    end
  endtask
`endif

  task automatic test_reset_mid();
    cyc(); div_en = 1'b0; div_val = 4'd0; halt_req = 1'b0; mid();
    cyc(); timer_en = 1'b1; mid();
    cyc(); mid();
    checks++;
    if ({cnt_en, halt_ack} !== 2'b10) begin
      errors++; $display("FAIL rm_run got %b exp 10", {cnt_en, halt_ack});
    end
`ifdef CNT_CTRL_DBG_HALT_EN
    cyc(); dbg_mode = 1'b1; halt_req = 1'b1; mid();
    cyc(); mid();
    checks++;
    if ({cnt_en, halt_ack} !== 2'b01) begin
      errors++; $display("FAIL rm_halt got %b exp 01", {cnt_en, halt_ack});
    end
`endif
    #1; rst_n = 1'b0; #1;
    checks++;
    if ({cnt_en, halt_ack} !== 2'b00) begin
      errors++; $display("FAIL rm_async got %b exp 00", {cnt_en, halt_ack});
    end
    cyc(); mid();
    checks++;
    if ({cnt_en, halt_ack} !== 2'b00) begin
      errors++; $display("FAIL rm_held got %b exp 00", {cnt_en, halt_ack});
    end
    cyc(); timer_en = 1'b0; halt_req = 1'b0; dbg_mode = 1'b0; rst_n = 1'b1; mid();
    checks++;
    if ({cnt_en, halt_ack} !== 2'b00) begin
      errors++; $display("FAIL rm_release got %b exp 00", {cnt_en, halt_ack});
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_div_off();
    test_presc();
    test_cfg_change();
`ifdef CNT_CTRL_DBG_HALT_EN
    test_halt();
    test_halt_clear();
`else
    test_no_halt();
`endif
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
